fabric_uart_rx: RTL and testbench
=================================

// Module: fabric_uart_rx
// PURPOSE
//  Fabric-side UART receiver; the far end of the MSS MMUART_0_TXD serial line.
//  Deserialises 8N1 frames, LSB first, and buffers the bytes in a show-ahead FIFO.
//  Fabric logic drains the FIFO with a valid/ready handshake.
//  Clocked from the fabric CCC clock. Sits beside the MSS subsystem in the top level.
// PARAMETERS
//  CLKS_PER_BIT  868  CLK cycles per bit (100 MHz / 115200). Must be >= 4.
//  FIFO_DEPTH    16   receive FIFO entries. Power of two, >= 2.
// PORTS
//  CLK         in   1   fabric clock; all logic on rising edge
//  RESET       in   1   synchronous, active-high reset
//  RXD         in   1   serial input, asynchronous to CLK; idle high
//  RX_DATA     out  8   byte at the FIFO head; valid while RX_VALID=1
//  RX_VALID    out  1   FIFO not empty
//  RX_READY    in   1   consumer accepts the head byte when RX_VALID & RX_READY
//  FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1   bytes currently held
//  FRAME_ERR   out  1   sticky: a stop bit was sampled low
//  OVERFLOW    out  1   sticky: a byte arrived while the FIFO was full
//  CLR_ERR     in   1   one-cycle pulse; clears FRAME_ERR and OVERFLOW
// BEHAVIOUR
//  Reset: RX_DATA=0, RX_VALID=0, FIFO_COUNT=0, FRAME_ERR=0, OVERFLOW=0.
//   FSM enters IDLE. Synchroniser flops preset to 1.
//   Reset mid-frame abandons the frame; no partial byte is pushed.
//  Input sync: 2-flop synchroniser, giving rxd_s. The edge detector uses the previous rxd_s.
//  Bit timer: down-counter, width $clog2(CLKS_PER_BIT)+1.
//  Bit counter: 0..7.
//  FSM:
//   IDLE  : on rxd_s falling edge, load timer = CLKS_PER_BIT/2 - 1, go to START.
//   START : at timer==0, sample rxd_s.
//           1 -> false start: return to IDLE, no flags change.
//           0 -> load timer = CLKS_PER_BIT-1, bitcnt=0, go to DATA.
//   DATA  : at each timer==0, shift rxd_s into shreg[7] (right shift, so LSB arrives first).
//           Reload the timer. After bitcnt==7 is sampled, go to STOP.
//   STOP  : at timer==0, sample rxd_s.
//           1 -> push shreg, go to IDLE.
//           0 -> set FRAME_ERR, discard the byte, go to BREAK.
//   BREAK : wait for rxd_s==1, then go to IDLE (no re-trigger during a line break).
//  Latency: the pushed byte shows on RX_DATA/RX_VALID the cycle after the stop-bit sample.
//   The stop-bit sample falls (CLKS_PER_BIT/2 + 9*CLKS_PER_BIT) cycles after the rxd_s falling edge.
//  FIFO: show-ahead. RX_DATA = mem[rd_ptr]. Pointers wrap modulo FIFO_DEPTH.
//   Pop when RX_VALID & RX_READY.
//   RX_READY while empty has no effect.
//   Push while full and no pop in the same cycle: byte dropped, OVERFLOW set, contents unchanged.
//   Push and pop in the same cycle, any level including full: both take effect, count unchanged.
//   FIFO_COUNT updates on the same edge as the push/pop.
//  Flags: sticky until CLR_ERR. If CLR_ERR and a new error event fall in the same cycle, the flag ends at 1.
//   Neither flag alters FSM or FIFO behaviour.
// TESTING
//  (CLKS_PER_BIT=8, FIFO_DEPTH=4 in the bench.)
//  1 Send 0xA5 8N1, RX_READY=0 -> RX_VALID rises, RX_DATA=0xA5, FIFO_COUNT=1, flags 0;
//    then pulse RX_READY -> FIFO_COUNT=0.
//  2 Low glitch of 2 cycles on idle RXD -> no byte, no flags, FSM back in IDLE.
//  3 Send 0x3C with the stop bit held low for 20 bit times -> FRAME_ERR=1, FIFO_COUNT=0;
//    then 0x81 -> received correctly.
//  4 Send 5 bytes 0x01..0x05 with RX_READY=0 -> FIFO_COUNT=4, OVERFLOW=1;
//    drain reads 01,02,03,04.
//  5 FIFO full, RX_READY=1 held on the cycle of the 5th push -> FIFO_COUNT stays 4, OVERFLOW=0;
//    order of bytes preserved.
//  6 RESET pulsed after bit 3 of a frame -> all outputs reset values; the next full 0x55 is received intact.

Source files
------------

// File: rtl/fabric_uart_rx.sv
// fabric_uart_rx
//   Fabric-side 8N1 UART receiver (LSB first) feeding a show-ahead receive FIFO
//   that the fabric drains with a valid/ready handshake.
//
// Ports
//   CLK         fabric clock, rising edge
//   RESET       synchronous, active-high reset
//   RXD         serial input, asynchronous to CLK, idle high
//   RX_DATA     byte at the FIFO head (meaningful while RX_VALID)
//   RX_VALID    FIFO not empty
//   RX_READY    consumer takes the head byte when RX_VALID & RX_READY
//   FIFO_COUNT  bytes currently held
//   FRAME_ERR   sticky: a stop bit was sampled low
//   OVERFLOW    sticky: a byte arrived while the FIFO was full
//   CLR_ERR     one-cycle pulse clearing both sticky flags
module fabric_uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          RXD,
    output logic [7:0]                    RX_DATA,
    output logic                          RX_VALID,
    input  logic                          RX_READY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          FRAME_ERR,
    output logic                          OVERFLOW,
    input  logic                          CLR_ERR
);

    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser; presets to the idle level so reset never looks
    // like a start edge.
    // ------------------------------------------------------------------
    logic rxd_m, rxd_s, rxd_prev;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rxd_m    <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_m    <= RXD;
            rxd_s    <= rxd_m;
            rxd_prev <= rxd_s;
        end
    end

    wire fall = rxd_prev & ~rxd_s;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;

    wire tick   = (timer == '0);
    wire push   = (state == S_STOP) && tick &&  rxd_s;
    wire fe_evt = (state == S_STOP) && tick && ~rxd_s;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= S_IDLE;
            timer  <= '0;
            bitcnt <= '0;
            shreg  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        timer <= T_HALF;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (rxd_s) begin
                            state <= S_IDLE;          // glitch, not a start bit
                        end else begin
                            timer  <= T_FULL;
                            bitcnt <= '0;
                            state  <= S_DATA;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shreg <= {rxd_s, shreg[7:1]};
                        timer <= T_FULL;
                        if (bitcnt == 3'd7) state  <= S_STOP;
                        else                bitcnt <= bitcnt + 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick) state <= rxd_s ? S_IDLE : S_BREAK;
                    else      timer <= timer - 1'b1;
                end
                S_BREAK: begin
                    // Hold off until the line returns high so a long break
                    // is not decoded as a stream of zero bytes.
                    if (rxd_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    wire full   = (FIFO_COUNT == CW'(FIFO_DEPTH));
    wire pop    = RX_VALID & RX_READY;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    wire wr_en  = push & (~full | pop);
    wire ov_evt = push & full & ~pop;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_COUNT <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   FIFO_COUNT <= FIFO_COUNT + 1'b1;
                2'b01:   FIFO_COUNT <= FIFO_COUNT - 1'b1;
                default: FIFO_COUNT <= FIFO_COUNT;
            endcase
        end
    end

    assign RX_DATA  = mem[rd_ptr];
    assign RX_VALID = (FIFO_COUNT != '0);

    // ------------------------------------------------------------------
    // Sticky flags; a new event wins over a simultaneous clear.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            FRAME_ERR <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            FRAME_ERR <= (FRAME_ERR & ~CLR_ERR) | fe_evt;
            OVERFLOW  <= (OVERFLOW  & ~CLR_ERR) | ov_evt;
        end
    end

endmodule

// File: tb/tb_fabric_uart_rx.sv
// tb_fabric_uart_rx
//   Directed bench for fabric_uart_rx with CLKS_PER_BIT=8, FIFO_DEPTH=4.
//   Inputs change on the falling clock edge; outputs are sampled there too.
module tb_fabric_uart_rx;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       RXD = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY = 1'b0;
    logic [2:0] FIFO_COUNT;
    logic       FRAME_ERR;
    logic       OVERFLOW;
    logic       CLR_ERR = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 CLK = ~CLK;

    fabric_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .RXD(RXD),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .FIFO_COUNT(FIFO_COUNT), .FRAME_ERR(FRAME_ERR), .OVERFLOW(OVERFLOW),
        .CLR_ERR(CLR_ERR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        RXD = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // One frame: start, 8 data bits LSB first, stop level held stop_len bit
    // times. If ready_at >= 0, RX_READY is high for exactly the cycle that
    // starts ready_at negedges after the start bit (78 lands on the push edge).
    task automatic send(input logic [7:0] b, input int stop_len, input logic stop_lvl,
                        input int ready_at);
        logic [9:0] bits;
        int         idx;
        bits = {1'b1, b, 1'b0};
        for (int n = 0; n < (9 + stop_len) * CPB; n++) begin
            idx = n / CPB;
            RXD = (idx >= 9) ? stop_lvl : bits[idx];
            if (ready_at >= 0) RX_READY = (n == ready_at);
            @(negedge CLK);
        end
        RX_READY = 1'b0;
        idle(8);
    endtask

    task automatic pop_one();
        RX_READY = 1'b1;
        @(negedge CLK);
        RX_READY = 1'b0;
    endtask

    task automatic clr_err();
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_b;

        // Reset
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_valid", RX_VALID, 0);
        check("rst_data",  RX_DATA, 8'h00);
        check("rst_count", FIFO_COUNT, 0);
        check("rst_fe",    FRAME_ERR, 0);
        check("rst_ov",    OVERFLOW, 0);
        idle(4);

        // 1: single byte, then drain
        send(8'hA5, 1, 1'b1, -1);
        check("t1_valid", RX_VALID, 1);
        check("t1_data",  RX_DATA, 8'hA5);
        check("t1_count", FIFO_COUNT, 1);
        check("t1_fe",    FRAME_ERR, 0);
        check("t1_ov",    OVERFLOW, 0);
        pop_one();
        check("t1_count_after_pop", FIFO_COUNT, 0);
        check("t1_valid_after_pop", RX_VALID, 0);

        // RX_READY while empty does nothing
        pop_one();
        check("t1_empty_pop_count", FIFO_COUNT, 0);

        // 2: 2-cycle low glitch is a false start
        RXD = 1'b0;
        repeat (2) @(negedge CLK);
        idle(30);
        check("t2_count", FIFO_COUNT, 0);
        check("t2_fe",    FRAME_ERR, 0);
        check("t2_ov",    OVERFLOW, 0);

        // 3: framing error with a long break, then a clean byte
        send(8'h3C, 20, 1'b0, -1);
        check("t3_fe",    FRAME_ERR, 1);
        check("t3_count", FIFO_COUNT, 0);
        send(8'h81, 1, 1'b1, -1);
        check("t3_count2", FIFO_COUNT, 1);
        check("t3_data2",  RX_DATA, 8'h81);
        check("t3_fe_sticky", FRAME_ERR, 1);
        clr_err();
        check("t3_fe_cleared", FRAME_ERR, 0);
        pop_one();
        check("t3_count3", FIFO_COUNT, 0);

        // 4: overflow with no consumer
        for (int i = 1; i <= 5; i++) send(8'(i), 1, 1'b1, -1);
        check("t4_count", FIFO_COUNT, 4);
        check("t4_ov",    OVERFLOW, 1);
        check("t4_fe",    FRAME_ERR, 0);
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i);
            check($sformatf("t4_drain%0d", i), RX_DATA, exp_b);
            pop_one();
        end
        check("t4_empty", FIFO_COUNT, 0);
        clr_err();
        check("t4_ov_cleared", OVERFLOW, 0);

        // 5: push and pop on the same edge while full
        for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1, 1'b1, -1);
        check("t5_full", FIFO_COUNT, 4);
        send(8'h15, 1, 1'b1, 78);
        check("t5_count", FIFO_COUNT, 4);
        check("t5_ov",    OVERFLOW, 0);
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'h12 + 8'(i);
            check($sformatf("t5_drain%0d", i), RX_DATA, exp_b);
            pop_one();
        end
        check("t5_empty", FIFO_COUNT, 0);

        // 6: reset mid-frame, with state to lose beforehand
        send(8'hC3, 1, 1'b1, -1);
        send(8'h00, 2, 1'b0, -1);
        check("t6_pre_count", FIFO_COUNT, 1);
        check("t6_pre_fe",    FRAME_ERR, 1);
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'h55, 1'b0};
            for (int n = 0; n < 5 * CPB; n++) begin   // start + bits 0..3
                RXD = bits[n / CPB];
                @(negedge CLK);
            end
        end
        RESET = 1'b1;
        RXD   = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("t6_valid", RX_VALID, 0);
        check("t6_data",  RX_DATA, 8'h00);
        check("t6_count", FIFO_COUNT, 0);
        check("t6_fe",    FRAME_ERR, 0);
        check("t6_ov",    OVERFLOW, 0);
        idle(100);
        check("t6_no_partial", FIFO_COUNT, 0);
        send(8'h55, 1, 1'b1, -1);
        check("t6_count2", FIFO_COUNT, 1);
        check("t6_data2",  RX_DATA, 8'h55);
        check("t6_fe2",    FRAME_ERR, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
